sha256_msg_sched: RTL and testbench

Message-schedule stage that sits directly upstream of the SHA-256 compression rounds. It accepts one 512-bit padded message block and streams the 64 schedule words W[0..63], one per handshake, to the round datapath. It uses the shared sigma0/sigma1 functions and keeps a 16-word sliding window, so W[16..63] are computed on the fly rather than stored.

---
 rtl/sha256_pkg.sv | 33 +++
 rtl/sha256_msg_sched_if.sv | 26 ++
 rtl/sha256_w_expand.sv | 14 +
 rtl/sha256_msg_sched.sv | 74 +++++++
 tb/tb_sha256_msg_sched.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, types and the message-schedule sigma functions.
package sha256_pkg;

    localparam int unsigned WORD_SIZE  = 32;
    localparam int unsigned ROUNDS     = 64;
    localparam int unsigned BLOCK_BITS = 512;
    localparam int unsigned IDX_W      = $clog2(ROUNDS);

    typedef logic [WORD_SIZE-1:0] word_t;
    typedef logic [IDX_W-1:0]     idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sched_state_t;

    localparam idx_t LAST_IDX = idx_t'(ROUNDS - 1);

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_SIZE - n));
    endfunction

    // Small sigma0: ROTR7 ^ ROTR18 ^ SHR3
    function automatic word_t sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    // Small sigma1: ROTR17 ^ ROTR19 ^ SHR10
    function automatic word_t sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_msg_sched_if.sv
// Block-input and schedule-word-output handshake bundle of the scheduler.
interface sha256_msg_sched_if;
    import sha256_pkg::*;

    logic                  blk_valid;
    logic                  blk_ready;
    logic [BLOCK_BITS-1:0] blk_data;
    logic                  w_valid;
    logic                  w_ready;
    word_t                 w_word;
    idx_t                  w_idx;
    logic                  w_last;
    logic                  busy;

    // Block source / word sink side
    modport master (
        output blk_valid, blk_data, w_ready,
        input  blk_ready, w_valid, w_word, w_idx, w_last, busy
    );

    // Scheduler side
    modport slave (
        input  blk_valid, blk_data, w_ready,
        output blk_ready, w_valid, w_word, w_idx, w_last, busy
    );
endinterface

// File: rtl/sha256_w_expand.sv
// Combinational schedule expansion: W[t] from W[t-2], W[t-7], W[t-15], W[t-16].
module sha256_w_expand
    import sha256_pkg::*;
(
    input  word_t w_m2,
    input  word_t w_m7,
    input  word_t w_m15,
    input  word_t w_m16,
    output word_t next_w
);

    assign next_w = sigma1(w_m2) + w_m7 + sigma0(w_m15) + w_m16;

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message scheduler: accepts one padded block, streams W[0..63].
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    sha256_msg_sched_if.slave   bus
);

    // Window is a packed 16-word vector in block order: element 15 holds the
    // oldest word (W[t]), element 0 the newest. Loading is then a plain copy of
    // blk_data and advancing is a single shift-in of the expanded word.
    typedef logic [15:0][WORD_SIZE-1:0] window_t;

    sched_state_t state_q, state_d;
    window_t      win_q, win_d;
    idx_t         t_q, t_d;
    word_t        next_w;

    sha256_w_expand u_expand (
        .w_m2   (win_q[1]),
        .w_m7   (win_q[6]),
        .w_m15  (win_q[14]),
        .w_m16  (win_q[15]),
        .next_w (next_w)
    );

    // Next-state: block load in IDLE, window advance on each accepted word
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        t_d     = t_q;
        case (state_q)
            IDLE: begin
                if (bus.blk_valid) begin
                    win_d   = bus.blk_data;
                    t_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.w_ready) begin
                    win_d = {win_q[14:0], next_w};
                    t_d   = t_q + 1'b1;
                    if (t_q == LAST_IDX) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, window and round-index registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            win_q   <= '0;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            t_q     <= t_d;
        end
    end

    assign bus.blk_ready = (state_q == IDLE);
    assign bus.w_valid   = (state_q == RUN);
    assign bus.busy      = (state_q == RUN);
    assign bus.w_word    = (state_q == RUN) ? win_q[15] : '0;
    assign bus.w_idx     = t_q;
    assign bus.w_last    = (state_q == RUN) && (t_q == LAST_IDX);

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched using directed blocks.
module tb_sha256_msg_sched;
    import sha256_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sha256_msg_sched_if bus();

    sha256_msg_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    word_t exp_w [64];
    word_t got_w [64];
    logic [511:0] abc_blk;
    logic [511:0] zero_blk;
    logic [511:0] b_blk;
    logic [511:0] tmp_blk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic word_t ss0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic word_t ss1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    task automatic build_ref(input logic [511:0] b);
        for (int i = 0; i < 16; i++) exp_w[i] = b[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            exp_w[i] = ss1(exp_w[i-2]) + exp_w[i-7] + ss0(exp_w[i-15]) + exp_w[i-16];
    endtask

    // Present a block at a negedge; it is taken on the next posedge.
    task automatic load_block(input logic [511:0] b);
        build_ref(b);
        chk("load_blk_ready", bus.blk_ready, 1);
        bus.blk_valid = 1'b1;
        bus.blk_data  = b;
        @(negedge clk);
        bus.blk_valid = 1'b0;
        chk("lat_w_valid", bus.w_valid, 1);
        chk("lat_w_idx", bus.w_idx, 0);
    endtask

    // Consume words until stop_at handshakes are done (64 = whole block).
    task automatic run_block(input int stop_at, input bit rnd, input bit scramble);
        int k = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        word_t pw = '0;
        idx_t pi = '0;
        logic pl = 1'b0;
        while (k < stop_at && cyc < 2000) begin
            if (stalled) begin
                chk("stall_valid", bus.w_valid, 1);
                chk("stall_word", bus.w_word, pw);
                chk("stall_idx", bus.w_idx, pi);
                chk("stall_last", bus.w_last, pl);
            end
            chk("run_blk_ready", bus.blk_ready, 0);
            chk("run_busy", bus.busy, 1);
            chk("run_w_valid", bus.w_valid, 1);
            bus.w_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (scramble) bus.blk_data = {16{$urandom()}};
            if (bus.w_ready) begin
                got_w[k] = bus.w_word;
                chk($sformatf("W%0d", k), bus.w_word, exp_w[k]);
                chk($sformatf("idx%0d", k), bus.w_idx, 64'(k));
                chk($sformatf("last%0d", k), bus.w_last, (k == 63) ? 1 : 0);
                k++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                pw = bus.w_word;
                pi = bus.w_idx;
                pl = bus.w_last;
            end
            @(negedge clk);
            cyc++;
        end
        bus.w_ready = 1'b0;
        if (k < stop_at) begin
            chk("timeout", 64'(k), 64'(stop_at));
        end else if (stop_at == 64) begin
            chk("end_blk_ready", bus.blk_ready, 1);
            chk("end_w_valid", bus.w_valid, 0);
            chk("end_busy", bus.busy, 0);
            chk("end_w_last", bus.w_last, 0);
        end
    endtask

    initial begin
        abc_blk  = {32'h61626380, 448'h0, 32'h00000018};
        zero_blk = '0;
        b_blk    = {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98,
                    32'h76543210, 32'h0F1E2D3C, 32'h4B5A6978, 32'h8796A5B4,
                    32'hC3D2E1F0, 32'h11111111, 32'h22222222, 32'h33333333,
                    32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777};
        bus.blk_valid = 1'b0;
        bus.blk_data  = '0;
        bus.w_ready   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_blk_ready", bus.blk_ready, 1);
        chk("rst_w_valid", bus.w_valid, 0);
        chk("rst_w_word", bus.w_word, 0);
        chk("rst_w_idx", bus.w_idx, 0);
        chk("rst_w_last", bus.w_last, 0);
        chk("rst_busy", bus.busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // "abc" block at full rate
        load_block(abc_blk);
        run_block(64, 1'b0, 1'b0);
        chk("abc_W0", got_w[0], 32'h61626380);
        chk("abc_W15", got_w[15], 32'h00000018);
        chk("abc_W16", got_w[16], 32'h61626380);
        chk("abc_W17", got_w[17], 32'h000F0000);

        // All-zero block
        load_block(zero_blk);
        run_block(64, 1'b0, 1'b0);

        // "abc" with random w_ready and blk_data churn during RUN
        load_block(abc_blk);
        run_block(64, 1'b1, 1'b1);
        chk("rnd_W17", got_w[17], 32'h000F0000);

        // Back-to-back blocks with blk_valid held high
        build_ref(abc_blk);
        bus.blk_data  = abc_blk;
        bus.blk_valid = 1'b1;
        @(negedge clk);
        bus.blk_data = b_blk;
        run_block(64, 1'b0, 1'b0);
        @(negedge clk);
        tmp_blk = b_blk;
        chk("b2b_w_valid", bus.w_valid, 1);
        chk("b2b_W0", bus.w_word, tmp_blk[511:480]);
        chk("b2b_idx", bus.w_idx, 0);
        bus.blk_valid = 1'b0;
        build_ref(b_blk);
        run_block(64, 1'b0, 1'b0);

        // Mid-block reset at w_idx 20
        load_block(abc_blk);
        run_block(20, 1'b0, 1'b0);
        chk("pre_rst_idx", bus.w_idx, 20);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_w_valid", bus.w_valid, 0);
        chk("mid_rst_blk_ready", bus.blk_ready, 1);
        chk("mid_rst_w_idx", bus.w_idx, 0);
        chk("mid_rst_w_word", bus.w_word, 0);
        chk("mid_rst_busy", bus.busy, 0);
        load_block(abc_blk);
        run_block(64, 1'b0, 1'b0);
        chk("post_rst_W0", got_w[0], 32'h61626380);
        chk("post_rst_W16", got_w[16], 32'h61626380);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
